la_wb_master: RTL and testbench
===============================

LA_WB_MASTER -- requirements
Module: la_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles in BUS without wbm_ack_i before abort; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1: command request from the logic-analyzer side.
REQ-005 SHALL have port cmd_ready, output, 1: block accepts a command.
REQ-006 SHALL have ports cmd_we (input, 1), cmd_adr (input, 32), cmd_dat (input, 32) and cmd_sel (input, 4): write flag, address, write data and byte lanes.
REQ-007 SHALL have port rsp_valid, output, 1: a response is held.
REQ-008 SHALL have port rsp_ready, input, 1: the consumer takes the response.
REQ-009 SHALL have ports rsp_dat (output, 32) and rsp_err (output, 1): read data and timeout flag.
REQ-010 SHALL have Wishbone initiator outputs wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_adr_o (32), wbm_dat_o (32) and wbm_sel_o (4).
REQ-011 SHALL have Wishbone initiator inputs wbm_ack_i (1) and wbm_dat_i (32).
REQ-012 SHALL have port txn_count, output, 16: count of completed transactions.

Function
REQ-013 SHALL implement FSM states IDLE, BUS and RESP.
REQ-014 SHALL drive cmd_ready=1 only in IDLE.
REQ-015 SHALL latch we/adr/dat/sel on a cmd_valid & cmd_ready edge and enter BUS on the next cycle.
REQ-016 SHALL assert wbm_cyc_o=wbm_stb_o=1 throughout BUS, with we/adr/dat/sel stable from the latched values; classic single-cycle handshake, no pipelining or bursts.
REQ-017 SHALL keep wbm_cyc_o=wbm_stb_o=0 in IDLE and RESP.
REQ-018 SHALL, on wbm_ack_i=1 in BUS: capture wbm_dat_i into rsp_dat on reads, set rsp_dat=0 on writes, set rsp_err=0 and enter RESP. Latency: ack at cycle M gives cyc/stb low and rsp_valid=1 at M+1.
REQ-019 SHALL clear the timeout counter on entry to BUS and increment it each BUS cycle without ack.
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYCLES, drop cyc/stb, set rsp_err=1 and rsp_dat=0, and enter RESP.
REQ-021 SHALL give ack priority when ack and timeout occur in the same cycle (rsp_err=0).
REQ-022 SHALL ignore wbm_ack_i outside BUS.
REQ-023 SHALL hold rsp_valid, rsp_dat and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on the next cycle. Minimum command-to-command period is 3 cycles plus ack wait.
REQ-024 SHALL increment txn_count by 1 on each RESP-to-IDLE transition, including errored transactions, wrapping 0xFFFF to 0x0000.
REQ-025 SHALL ignore cmd_valid while not in IDLE; commands are not queued.

Reset
REQ-026 SHALL, while wb_rst_i=1, force state=IDLE, cmd_ready=0, all wbm_* outputs=0, rsp_valid=0, rsp_dat=0, rsp_err=0, txn_count=0 and the timeout counter=0, asynchronously.
REQ-027 SHALL, on reset asserted mid-BUS, drop cyc/stb immediately without producing a response.
REQ-028 SHALL drive cmd_ready=1 on the first clock edge after reset release.

Structure
REQ-029 SHALL place the FSM state enum and WB_ADDR_W=32, WB_DATA_W=32 and WB_SEL_W=4 in the shared package la_wb_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover a write: cmd adr=0x3000_0004, dat=0xA5A5_0001, sel=0xF, we=1, slave acks on the 2nd BUS cycle -> one cyc/stb pulse with those values, rsp_valid with rsp_err=0, txn_count=1.
REQ-032 SHALL cover a read: adr=0x3000_0000, slave returns 0x0000_0ABC with ack on the 1st BUS cycle -> rsp_dat=0x0000_0ABC, rsp_valid asserted one cycle after ack.
REQ-033 SHALL cover a timeout: TIMEOUT_CYCLES=8, slave never acks -> cyc/stb high exactly 8 cycles, then rsp_err=1 and rsp_dat=0.
REQ-034 SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> response stable, cmd_ready=0 and a new cmd_valid is ignored; rsp_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset mid-operation: wb_rst_i pulsed mid-BUS -> cyc/stb low without a clock edge, no rsp_valid, txn_count=0.
REQ-036 SHALL cover wrap and ack priority: preload txn_count=0xFFFF and complete one transaction -> txn_count=0x0000; with TIMEOUT_CYCLES=4 and ack in the timeout cycle -> rsp_err=0.

Source files
------------

// File: rtl/la_wb_pkg.sv
// Shared definitions for the logic-analyzer Wishbone master: bus widths and
// the transaction FSM state encoding.
package la_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } la_wb_state_t;

endpackage

// File: rtl/la_wb_master.sv
// Single-transaction Wishbone classic initiator driven by a logic-analyzer
// command/response port, with a per-transaction ack timeout.
module la_wb_master
    import la_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both 1; valid must not depend on ready.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [WB_ADDR_W-1:0] cmd_adr,
    input  logic [WB_DATA_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0]  cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DATA_W-1:0] rsp_dat,
    output logic                 rsp_err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_ADDR_W-1:0] wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    input  logic                 wbm_ack_i,
    input  logic [WB_DATA_W-1:0] wbm_dat_i,
    output logic [15:0]          txn_count,
    output logic [1:0]           fsm_state
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    la_wb_state_t state, state_nxt;
    logic [15:0]  tmo_cnt;
    logic         accept;
    logic         bus_ack;
    logic         bus_tmo;

    assign accept  = cmd_valid & cmd_ready;
    assign bus_ack = (state == ST_BUS) & wbm_ack_i;
    // Counter holds the number of ack-less BUS cycles already elapsed, so the
    // last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign bus_tmo = (state == ST_BUS) & ~wbm_ack_i & (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUS;
            ST_BUS:  if (bus_ack || bus_tmo) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
            txn_count <= '0;
        end else begin
            state     <= state_nxt;
            // Registered so that it rises on the first edge after reset release.
            cmd_ready <= (state_nxt == ST_IDLE);
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                wbm_sel_o <= cmd_sel;
                tmo_cnt   <= '0;
            end
            if (state == ST_BUS && !wbm_ack_i) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (bus_ack) begin
                rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (bus_tmo) begin
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    assign wbm_cyc_o = (state == ST_BUS);
    assign wbm_stb_o = (state == ST_BUS);
    assign rsp_valid = (state == ST_RESP);
    assign fsm_state = state;

endmodule

// File: tb/tb_la_wb_master.sv
// Bench for la_wb_master: two instances (timeout 8 and 4) share command and
// response stimulus; a selector steers cmd_valid/ack to one of them.
module tb_la_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel4 = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_ready = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    logic        cmd_valid8, cmd_valid4, ack8, ack4;
    logic        cmd_ready8, rsp_valid8, rsp_err8, cyc8, stb8, we8;
    logic        cmd_ready4, rsp_valid4, rsp_err4, cyc4, stb4, we4;
    logic [31:0] rsp_dat8, adr8, dat8, rsp_dat4, adr4, dat4;
    logic [3:0]  bsel8, bsel4;
    logic [15:0] cnt8, cnt4;
    logic [1:0]  st8, st4;

    logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_cyc, m_stb, m_we;
    logic [31:0] m_rsp_dat, m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [15:0] m_cnt;
    logic [1:0]  m_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt8 = '0;
    logic [15:0] exp_cnt4 = '0;

    assign cmd_valid8 = cmd_valid & ~sel4;
    assign cmd_valid4 = cmd_valid & sel4;
    assign ack8       = ack & ~sel4;
    assign ack4       = ack & sel4;

    assign m_cmd_ready = sel4 ? cmd_ready4 : cmd_ready8;
    assign m_rsp_valid = sel4 ? rsp_valid4 : rsp_valid8;
    assign m_rsp_err   = sel4 ? rsp_err4   : rsp_err8;
    assign m_rsp_dat   = sel4 ? rsp_dat4   : rsp_dat8;
    assign m_cyc       = sel4 ? cyc4       : cyc8;
    assign m_stb       = sel4 ? stb4       : stb8;
    assign m_we        = sel4 ? we4        : we8;
    assign m_adr       = sel4 ? adr4       : adr8;
    assign m_dat       = sel4 ? dat4       : dat8;
    assign m_sel       = sel4 ? bsel4      : bsel8;
    assign m_cnt       = sel4 ? cnt4       : cnt8;
    assign m_state     = sel4 ? st4        : st8;

    la_wb_master #(.TIMEOUT_CYCLES(8)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat8), .rsp_err(rsp_err8),
        .wbm_cyc_o(cyc8), .wbm_stb_o(stb8), .wbm_we_o(we8),
        .wbm_adr_o(adr8), .wbm_dat_o(dat8), .wbm_sel_o(bsel8),
        .wbm_ack_i(ack8), .wbm_dat_i(wbm_dat_i),
        .txn_count(cnt8), .fsm_state(st8)
    );

    la_wb_master #(.TIMEOUT_CYCLES(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat4), .rsp_err(rsp_err4),
        .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(we4),
        .wbm_adr_o(adr4), .wbm_dat_o(dat4), .wbm_sel_o(bsel4),
        .wbm_ack_i(ack4), .wbm_dat_i(wbm_dat_i),
        .txn_count(cnt4), .fsm_state(st4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. d = BUS cycle on which the slave acks (beyond the
    // timeout means never); hold = cycles the consumer stalls the response.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rd,
                           input int d, input int hold);
        int          t;
        int          n;
        int          e_n;
        logic        e_err;
        logic [31:0] e_dat;
        t     = sel4 ? 4 : 8;
        e_err = (d > t);
        e_n   = e_err ? t : d;
        e_dat = (e_err || we) ? 32'd0 : rd;

        @(negedge clk);
        check("cmd_ready_idle", 32'(m_cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!m_cyc) break;
            n++;
            check("bus_stb", 32'(m_stb), 32'd1);
            check("bus_we", 32'(m_we), 32'(we));
            check("bus_adr", m_adr, adr);
            check("bus_dat", m_dat, dat);
            check("bus_sel", 32'(m_sel), 32'(sel));
            check("bus_cmd_ready", 32'(m_cmd_ready), 32'd0);
            ack = (n == d);
            wbm_dat_i = rd;
            @(posedge clk);
            #1 ack = 1'b0;
        end
        check("bus_cycles", 32'(n), 32'(e_n));
        check("rsp_valid", 32'(m_rsp_valid), 32'd1);
        check("rsp_dat", m_rsp_dat, e_dat);
        check("rsp_err", 32'(m_rsp_err), 32'(e_err));
        check("rsp_stb_low", 32'(m_stb), 32'd0);

        for (int c = 0; c < hold; c++) begin
            cmd_valid = 1'b1;
            cmd_adr   = $urandom;
            ack       = 1'b1;
            wbm_dat_i = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(m_rsp_valid), 32'd1);
            check("hold_dat", m_rsp_dat, e_dat);
            check("hold_err", 32'(m_rsp_err), 32'(e_err));
            check("hold_cmd_ready", 32'(m_cmd_ready), 32'd0);
            check("hold_cyc", 32'(m_cyc), 32'd0);
        end
        cmd_valid = 1'b0;
        ack       = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (sel4) exp_cnt4 = exp_cnt4 + 16'd1;
        else      exp_cnt8 = exp_cnt8 + 16'd1;
        check("idle_state", 32'(m_state), 32'd0);
        check("idle_valid", 32'(m_rsp_valid), 32'd0);
        check("idle_cmd_ready", 32'(m_cmd_ready), 32'd1);
        check("txn_count", 32'(m_cnt), 32'(sel4 ? exp_cnt4 : exp_cnt8));
        check("adr_kept", m_adr, adr);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_cmd_ready", 32'(cmd_ready8), 32'd0);
        check("rst_cyc", 32'(cyc8), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid8), 32'd0);
        check("rst_adr", adr8, 32'd0);
        check("rst_count", 32'(cnt8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rel_cmd_ready_pre", 32'(cmd_ready8), 32'd0);
        @(posedge clk);
        #1 check("rel_cmd_ready_post", 32'(cmd_ready8), 32'd1);

        // Directed write, read, timeout, backpressure
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 32'hDEAD_BEEF, 2, 0);
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h0000_0ABC, 1, 0);
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 32'h1234_5678, 1000, 0);
        run_txn(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h1, 32'h0, 3, 5);
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 32'hCAFE_F00D, 8, 0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom, $urandom_range(1, 10), $urandom_range(0, 3));
        end

        // Ack in the timeout cycle wins, then a plain timeout, on the short instance
        sel4 = 1'b1;
        run_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'h0BAD_C0DE, 4, 0);
        run_txn(1'b0, 32'h4000_0004, 32'h0, 4'hF, 32'h0BAD_C0DE, 5, 1);
        sel4 = 1'b0;

        // Counter wrap
        @(negedge clk);
        force u_dut8.txn_count = 16'hFFFF;
        #1 release u_dut8.txn_count;
        exp_cnt8 = 16'hFFFF;
        run_txn(1'b1, 32'h3000_0030, 32'h0000_0001, 4'hF, 32'h0, 1, 0);
        check("wrap_zero", 32'(cnt8), 32'd0);

        // Reset in the middle of BUS
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_bus_cyc", 32'(cyc8), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cyc", 32'(cyc8), 32'd0);
        check("mid_rst_stb", 32'(stb8), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid8), 32'd0);
        check("mid_rst_count", 32'(cnt8), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready8), 32'd0);
        exp_cnt8 = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("mid_rel_cmd_ready", 32'(cmd_ready8), 32'd1);
        check("mid_rel_valid", 32'(rsp_valid8), 32'd0);
        run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 32'h0000_0777, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
